odd_parity_serial_tx: RTL and testbench
=======================================

// Module: odd_parity_serial_tx
// PURPOSE
//  Serial transmit stage downstream of the byte-level odd parity generator.
//  - Accepts one data word per valid/ready handshake.
//  - Computes the odd parity bit internally.
//  - Shifts out a frame: start(0), data LSB first, parity, stop(1).
//  - Each bit is held for a programmable number of clocks.
//  Feeds the board-level serial line and the far-end parity checker.
// PARAMETERS
//  DATA_W        8   data bits per frame; legal range >= 1
//  CLKS_PER_BIT  4   clocks each serial bit is held; legal range >= 1, value 1 must work
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       synchronous, active-low reset
//  data_in     in   DATA_W  word to transmit; sampled only on handshake
//  data_valid  in   1       upstream has a word
//  data_ready  out  1       block can accept; high only in IDLE
//  tx_out      out  1       serial line, idles high
//  busy        out  1       high while a frame is in progress (state != IDLE)
//  parity_out  out  1       parity bit of the latched word, held until next accept
// BEHAVIOUR
//  - Reset values (rst_n=0 at a clk edge):
//    state=IDLE, tx_out=1, busy=0, data_ready=1, parity_out=0.
//    Bit counter, clock counter and shift register all clear to 0.
//  - Reset mid-frame aborts the frame. tx_out=1 on the next edge; no partial stop bit.
//  - Handshake: accept occurs when data_valid && data_ready at a clk edge.
//    - Latch data_in into the shift register.
//    - parity_out <= ~^data_in. Data plus parity then has an odd count of ones.
//  - data_valid is ignored while busy. data_in may change freely when not accepted.
//  - FSM states and transitions:
//    - IDLE -> START on accept.
//    - START -> DATA after CLKS_PER_BIT clocks.
//    - DATA -> PARITY after DATA_W bit-times.
//    - PARITY -> STOP after CLKS_PER_BIT clocks.
//    - STOP -> IDLE after CLKS_PER_BIT clocks.
//  - tx_out by state: IDLE 1; START 0; DATA shreg[0], shifting right once per bit-time;
//    PARITY parity_out; STOP 1.
//  - tx_out is registered. It goes low on the edge of accept.
//  - Each bit level holds exactly CLKS_PER_BIT cycles.
//  - Frame length: (DATA_W+3)*CLKS_PER_BIT cycles.
//    data_ready returns high in the first cycle after the last STOP cycle.
//  - Back-to-back: if data_valid is held high, the next accept happens in that first IDLE cycle.
//    The minimum line gap is therefore 1 IDLE cycle (tx_out=1) plus the stop bit.
//  - Counters:
//    - Clock counter is $clog2(CLKS_PER_BIT+1) bits wide. Reloads at each bit boundary; never wraps mid-bit.
//    - Bit counter is $clog2(DATA_W+1) bits wide.
//  - busy = (state != IDLE). data_ready = (state == IDLE).
//    Both are derived from registered state and are never combinational from data_valid.
// TESTING
//  1. Reset check: rst_n low 3 cycles, then release.
//     -> tx_out=1, busy=0, data_ready=1; no line activity without valid.
//  2. data_in=8'hA5 (four ones), CLKS_PER_BIT=4.
//     -> parity_out=1.
//     -> line reads 0,1,0,1,0,0,1,0,1,1,1, each bit 4 cycles.
//     -> data_ready high again 44 cycles after accept.
//  3. data_in=8'h07 (three ones) -> parity bit 0.
//     data_in=8'h00 -> parity bit 1. data_in=8'hFF -> parity bit 1.
//     Ones count over data+parity is odd in every case.
//  4. Back-to-back: data_valid held high with 8'h01 then 8'h80.
//     -> second start bit begins exactly 1 cycle after the first stop bit ends.
//     -> no word is lost or duplicated.
//  5. Toggle data_valid and data_in during a frame.
//     -> the frame in flight is unchanged; no accept until data_ready=1.
//  6. Assert rst_n=0 during the DATA state of 8'h3C.
//     -> tx_out=1 and state=IDLE on the next edge.
//     -> a fresh 8'h3C frame after release is bit-exact.
//     Also repeat test 2 with CLKS_PER_BIT=1: 11-cycle frame.

Source files
------------

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter: start, DATA_W data bits LSB first, odd parity, stop.
// Each bit held CLKS_PER_BIT clocks; one word per valid/ready handshake.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   data_in    - word to send, sampled on accept
//   data_valid - upstream has a word
//   data_ready - high only in IDLE
//   tx_out     - registered serial line, idles high
//   busy       - frame in progress
//   parity_out - odd parity of the latched word
module odd_parity_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              parity_out
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     clk_cnt, clk_cnt_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              tx_n, par_n;
    logic              accept, bit_end;

    assign data_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = data_valid && data_ready;
    assign bit_end    = (clk_cnt == CLK_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx_out     <= 1'b1;
            parity_out <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            tx_out     <= tx_n;
            parity_out <= par_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        tx_n      = tx_out;
        par_n     = parity_out;
        // Reload at each bit boundary so a bit never spans a wrap.
        if (state == IDLE) begin
            clk_cnt_n = '0;
        end else if (bit_end) begin
            clk_cnt_n = '0;
        end else begin
            clk_cnt_n = clk_cnt + CW'(1);
        end
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = START;
                    tx_n      = 1'b0;
                    shreg_n   = data_in;
                    par_n     = ~^data_in;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                    shreg_n = shreg >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY;
                        tx_n    = parity_out;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed bench for odd_parity_serial_tx at CLKS_PER_BIT 4 and 1.
// Frames are hand-written as {stop, parity, data, start}.
module tb_odd_parity_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       v4 = 1'b0, v1 = 1'b0;
    logic       rdy4, tx4, busy4, par4;
    logic       rdy1, tx1, busy1, par1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    odd_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(v4),
        .data_ready(rdy4), .tx_out(tx4), .busy(busy4), .parity_out(par4)
    );

    odd_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(v1),
        .data_ready(rdy1), .tx_out(tx1), .busy(busy1), .parity_out(par1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word at the negedge, accept on the next posedge.
    task automatic accept(input bit fast, input logic [7:0] d,
                          input bit hold, input logic exp_par, input string tag);
        @(negedge clk);
        chk({tag, "_rdy_before"}, fast ? rdy1 : rdy4, 1);
        din = d;
        if (fast) v1 = 1'b1; else v4 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            v1 = 1'b0;
            v4 = 1'b0;
        end
        chk({tag, "_busy"}, fast ? busy1 : busy4, 1);
        chk({tag, "_rdy_low"}, fast ? rdy1 : rdy4, 0);
        chk({tag, "_parity"}, fast ? par1 : par4, exp_par);
        chk({tag, "_odd_ones"}, $countones({d, exp_par}) % 2, 1);
    endtask

    // Called #1 after the accept edge; ends #1 after the first IDLE edge.
    task automatic run_frame(input bit fast, input logic [10:0] f,
                             input string tag);
        int cpb = fast ? 1 : 4;
        for (int c = 0; c < 11 * cpb; c++) begin
            chk($sformatf("%s_bit%0d", tag, c / cpb), fast ? tx1 : tx4,
                f[c / cpb]);
            @(posedge clk);
            #1;
        end
        chk({tag, "_rdy_after"}, fast ? rdy1 : rdy4, 1);
        chk({tag, "_idle_tx"}, fast ? tx1 : tx4, 1);
        chk({tag, "_idle_busy"}, fast ? busy1 : busy4, 0);
    endtask

    initial begin
        // 1. reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_rdy", rdy4, 1);
        chk("rst_par", par4, 0);
        chk("rst_tx1", tx1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("quiet_tx", tx4, 1);
        chk("quiet_busy", busy4, 0);

        // 2. A5 at 4 clocks/bit: 0,1,0,1,0,0,1,0,1,1,1
        accept(0, 8'hA5, 0, 1'b1, "a5");
        run_frame(0, 11'h74A, "a5");

        // 3. parity cases
        accept(0, 8'h07, 0, 1'b0, "h07");
        run_frame(0, 11'h40E, "h07");
        accept(0, 8'h00, 0, 1'b1, "h00");
        run_frame(0, 11'h600, "h00");
        accept(0, 8'hFF, 0, 1'b1, "hff");
        run_frame(0, 11'h7FE, "hff");

        // 4. back-to-back with valid held high
        accept(0, 8'h01, 1, 1'b0, "b2b01");
        din = 8'h80;
        run_frame(0, 11'h402, "b2b01");
        @(posedge clk);
        #1;
        v4 = 1'b0;
        chk("b2b80_start", tx4, 0);
        chk("b2b80_par", par4, 0);
        run_frame(0, 11'h500, "b2b80");
        @(posedge clk);
        #1;
        chk("b2b_no_dup_busy", busy4, 0);
        chk("b2b_no_dup_tx", tx4, 1);

        // 5. toggle valid and data during a frame
        accept(0, 8'hA5, 0, 1'b1, "tog");
        fork
            run_frame(0, 11'h74A, "tog");
            begin
                repeat (30) begin
                    @(negedge clk);
                    v4 = ~v4;
                    din = 8'($urandom);
                end
                v4 = 1'b0;
            end
        join
        chk("tog_par_held", par4, 1);
        @(posedge clk);
        #1;
        chk("tog_no_accept", busy4, 0);

        // 6. reset during DATA of 3C, then a clean 3C frame
        accept(0, 8'h3C, 0, 1'b1, "r3c");
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", tx4, 1);
        chk("abort_busy", busy4, 0);
        chk("abort_rdy", rdy4, 1);
        chk("abort_par", par4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(0, 8'h3C, 0, 1'b1, "f3c");
        run_frame(0, 11'h678, "f3c");

        // A5 at 1 clock/bit: 11-cycle frame
        accept(1, 8'hA5, 0, 1'b1, "fast");
        run_frame(1, 11'h74A, "fast");
        chk("fast_other_idle", busy4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
